// File: rtl/residual_add.sv
// residual_add -- saturating residual adder for a streaming inference pipeline.
//
// Buffers the skip-connection stream in a small FIFO and adds each incoming
// activation (from the upstream Leaky ReLU stage) to the oldest buffered skip
// element. The sum is computed one bit wider and clamped to the signed
// DATA_WIDTH range, then held in a single output register (1-cycle latency,
// one element per cycle at full throughput). out_last marks the final element
// of each TENSOR_LEN-element tensor.
//
// Optional feature: define RESADD_SAT_CNT_EN to add the sat_count port, a
// 16-bit sticky-at-max counter of act transfers whose sum was clamped.
//
// Ports:
//   clk                       rising-edge clock
//   rst_n                     synchronous active-low reset
//   skip_valid/ready/data     skip-connection input stream
//   act_valid/ready/data      activation input stream
//   out_valid/ready/data      residual sum output stream
//   out_last                  high with the final element of each tensor
//   sat_count                 (RESADD_SAT_CNT_EN only) clamp event counter
module residual_add #(
    parameter int DATA_WIDTH = 16,
    parameter int SKIP_DEPTH = 16,
    parameter int TENSOR_LEN = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  skip_valid,
    output logic                  skip_ready,
    input  logic [DATA_WIDTH-1:0] skip_data,
    input  logic                  act_valid,
    output logic                  act_ready,
    input  logic [DATA_WIDTH-1:0] act_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
`ifdef RESADD_SAT_CNT_EN
    ,
    output logic [15:0]           sat_count
`endif
);

    localparam int ADDR_W = $clog2(SKIP_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int IDX_W  = (TENSOR_LEN > 1) ? $clog2(TENSOR_LEN) : 1;

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(TENSOR_LEN - 1);

    // Skip FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem [SKIP_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;

    logic                  push;
    logic                  pop;

    // Adder datapath
    logic [DATA_WIDTH:0]   sum_wide;
    logic                  clamped;
    logic [DATA_WIDTH-1:0] sum_sat;

    logic [IDX_W-1:0]      idx;

    assign fifo_full  = (count == CNT_W'(SKIP_DEPTH));
    assign fifo_empty = (count == '0);
    assign fifo_head  = mem[rd_ptr];

    // Readiness depends only on registered state (and out_ready), so a skip
    // element pushed this cycle cannot be consumed until the next one, and a
    // full FIFO stays closed even when a pop happens in the same cycle.
    assign skip_ready = rst_n && !fifo_full;
    assign act_ready  = rst_n && !fifo_empty && (!out_valid || out_ready);

    assign push = skip_valid && skip_ready;
    assign pop  = act_valid && act_ready;

    // NOTE: combinational blocks assign every output up front so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        sum_wide = '0;
        clamped  = 1'b0;
        sum_sat  = '0;
        // Sign-extend both operands by one bit; the extra bit cannot overflow.
        sum_wide = {act_data[DATA_WIDTH-1], act_data} + {fifo_head[DATA_WIDTH-1], fifo_head};
        // Overflow of the DATA_WIDTH result shows as disagreement between the
        // two top bits; the very top bit then carries the true sign.
        clamped  = (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]);
        if (clamped) begin
            sum_sat = sum_wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            sum_sat = sum_wide[DATA_WIDTH-1:0];
        end
    end

    // NOTE: the storage array has no reset; its contents are unreachable until
    // written because the pointers and occupancy are cleared, and leaving it
    // out of reset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= skip_data;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output register: an act transfer always reloads it (full throughput),
    // otherwise a completed output transfer empties it; otherwise it holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            idx       <= '0;
        end else begin
            if (pop) begin
                out_valid <= 1'b1;
                out_data  <= sum_sat;
                out_last  <= (idx == IDX_LAST);
                idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RESADD_SAT_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (pop && clamped && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_residual_add.sv
// tb_residual_add -- randomized self-checking bench for residual_add.
// Reference model: a queue of buffered skip values, a queue of pending
// outputs and an element counter, all updated from observed handshakes.
module tb_residual_add;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int TL    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          skip_valid;
    logic          skip_ready;
    logic [DW-1:0] skip_data;
    logic          act_valid;
    logic          act_ready;
    logic [DW-1:0] act_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
`ifdef RESADD_SAT_CNT_EN
    logic [15:0]   sat_count;
`endif

    always #5 clk = ~clk;

    residual_add #(
        .DATA_WIDTH (DW),
        .SKIP_DEPTH (DEPTH),
        .TENSOR_LEN (TL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .skip_valid (skip_valid),
        .skip_ready (skip_ready),
        .skip_data  (skip_data),
        .act_valid  (act_valid),
        .act_ready  (act_ready),
        .act_data   (act_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
`ifdef RESADD_SAT_CNT_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } out_t;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] skip_q[$];
    out_t          exp_q[$];
    int            idx_m  = 0;
    int            sat_m  = 0;
    logic          last_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Saturating signed add computed with plain integer arithmetic.
    // Returns {clamped, result}.
    function automatic logic [DW:0] sat_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767)  return {1'b1, 16'h7FFF};
        if (s < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(s)};
    endfunction

    // Called at a falling edge with inputs already driven; checks the DUT
    // against the model, advances the model, then moves to the next falling edge.
    task automatic cycle();
        bit          sf, af, of;
        logic [DW:0] r;
        out_t        e;
        #1;
        if (!rst_n) begin
            check("rst_skip_ready", 32'(skip_ready), 32'd0);
            check("rst_act_ready",  32'(act_ready),  32'd0);
            skip_q.delete();
            exp_q.delete();
            idx_m = 0;
            sat_m = 0;
        end else begin
            check("skip_ready", 32'(skip_ready), 32'(skip_q.size() < DEPTH));
            check("act_ready",  32'(act_ready),
                  32'(skip_q.size() > 0 && (exp_q.size() == 0 || out_ready)));
            check("out_valid",  32'(out_valid),  32'(exp_q.size() > 0));
            if (out_valid && exp_q.size() > 0) begin
                check("out_data", 32'(out_data), 32'(exp_q[0].data));
                check("out_last", 32'(out_last), 32'(exp_q[0].last));
            end
            sf = skip_valid && skip_ready;
            af = act_valid && act_ready;
            of = out_valid && out_ready;
            if (of && exp_q.size() > 0) begin
                last_log.push_back(out_last);
                void'(exp_q.pop_front());
            end
            if (af && skip_q.size() > 0) begin
                r      = sat_ref(act_data, skip_q.pop_front());
                e.data = r[DW-1:0];
                e.last = (idx_m == TL - 1);
                exp_q.push_back(e);
                if (r[DW] && sat_m < 65535) sat_m++;
                idx_m = (idx_m + 1) % TL;
            end
            if (sf) skip_q.push_back(skip_data);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic sv, input logic [DW-1:0] sd,
                         input logic av, input logic [DW-1:0] ad, input logic ordy);
        skip_valid = sv;
        skip_data  = sd;
        act_valid  = av;
        act_data   = ad;
        out_ready  = ordy;
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, '0, 0, '0, 1);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((skip_q.size() > 0 || exp_q.size() > 0) && n < 200) begin
            drive(0, '0, 1, 16'($urandom), 1);
            n++;
        end
        check("drain_bound", 32'(n < 200), 32'd1);
        drive(0, '0, 0, '0, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        skip_valid = 1'b0;
        skip_data  = '0;
        act_valid  = 1'b0;
        act_data   = '0;
        out_ready  = 1'b1;
        @(negedge clk);

        // Reset state
        drive(0, '0, 0, '0, 1);
        drive(0, '0, 0, '0, 1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data",  32'(out_data),  32'd0);
        check("reset_out_last",  32'(out_last),  32'd0);
`ifdef RESADD_SAT_CNT_EN
        check("reset_sat_count", 32'(sat_count), 32'd0);
`endif
        rst_n = 1'b1;

        // Basic add; act_ready stays low while empty and in the push cycle
        drive(0, '0,      1, 16'h0200, 1);
        drive(1, 16'h0100, 1, 16'h0200, 1);
        drive(0, '0,      1, 16'h0200, 1);
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_sum",   32'(out_data),  32'h0300);
        drive(0, '0, 0, '0, 1);

        // Saturation both ways
        do_reset();
        drive(1, 16'h7000, 0, '0, 1);
        drive(1, 16'h9000, 0, '0, 1);
        drive(0, '0, 1, 16'h2000, 1);
        check("sat_pos", 32'(out_data), 32'h7FFF);
        drive(0, '0, 1, 16'hC000, 1);
        check("sat_neg", 32'(out_data), 32'h8000);
        drive(0, '0, 0, '0, 1);
`ifdef RESADD_SAT_CNT_EN
        check("sat_count_2", 32'(sat_count), 32'd2);
`endif

        // Fill the FIFO, then attempt one more push
        for (int i = 0; i < DEPTH; i++) drive(1, 16'($urandom), 0, '0, 1);
        check("full_skip_ready", 32'(skip_ready), 32'd0);
        drive(1, 16'h1234, 0, '0, 1);
        drain();

        // Back-to-back framing with TENSOR_LEN=4
        do_reset();
        last_log.delete();
        for (int i = 0; i < 8; i++) drive(1, 16'($urandom_range(0, 255)), 0, '0, 1);
        for (int i = 0; i < 8; i++) drive(0, '0, 1, 16'($urandom_range(0, 255)), 1);
        drive(0, '0, 0, '0, 1);
        check("b2b_count", 32'(last_log.size()), 32'd8);
        for (int k = 0; k < last_log.size(); k++)
            check("b2b_last_pos", 32'(last_log[k]), 32'((k % 4) == 3));

        // Output stall for 5 cycles
        drive(1, 16'h0011, 0, '0, 1);
        drive(1, 16'h0022, 0, '0, 1);
        drive(0, '0, 1, 16'h0100, 0);
        for (int i = 0; i < 5; i++) drive(0, '0, 1, 16'h0200, 0);
        check("stall_data", 32'(out_data), 32'h0111);
        drain();

        // Reset mid-tensor, then a fresh tensor frames from index 0
        for (int i = 0; i < 4; i++) drive(1, 16'(i), 0, '0, 1);
        for (int i = 0; i < 3; i++) drive(0, '0, 1, 16'h0010, 1);
        do_reset();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_act_ready", 32'(act_ready), 32'd0);
        last_log.delete();
        for (int i = 0; i < 4; i++) drive(1, 16'(i), 0, '0, 1);
        for (int i = 0; i < 4; i++) drive(0, '0, 1, 16'h0010, 1);
        drive(0, '0, 0, '0, 1);
        check("midrst_count", 32'(last_log.size()), 32'd4);
        for (int k = 0; k < last_log.size(); k++)
            check("midrst_last_pos", 32'(last_log[k]), 32'(k == 3));

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom),
                  1'($urandom_range(0, 3) != 0), 16'($urandom),
                  1'($urandom_range(0, 3) != 0));
        drain();
        check("end_out_valid",  32'(out_valid),  32'd0);
        check("end_act_ready",  32'(act_ready),  32'd0);
        check("end_skip_ready", 32'(skip_ready), 32'd1);
`ifdef RESADD_SAT_CNT_EN
        check("end_sat_count", 32'(sat_count), 32'(sat_m));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/residual_add.md
RESIDUAL_ADD -- requirements
Module: residual_add

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed element width of all data ports.
REQ-002 SHALL have parameter SKIP_DEPTH, default 16: skip-path FIFO depth in elements, power of 2, minimum 2.
REQ-003 SHALL have parameter TENSOR_LEN, default 64: elements per tensor, used for out_last framing.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports skip_valid input 1 / skip_ready output 1 / skip_data input DATA_WIDTH: skip-connection stream.
REQ-007 SHALL have ports act_valid input 1 / act_ready output 1 / act_data input DATA_WIDTH: activation stream from the upstream Leaky ReLU stage.
REQ-008 SHALL have ports out_valid output 1 / out_ready input 1 / out_data output DATA_WIDTH: residual sum stream.
REQ-009 SHALL have port out_last  output  1  high with the final element of each tensor.

Function
REQ-010 SHALL transfer on any stream only in a cycle where valid and ready are both high.
REQ-011 SHALL buffer skip elements in a SKIP_DEPTH-entry FIFO; skip_ready = FIFO not full, with no combinational dependence on skip_valid.
REQ-012 SHALL, when the FIFO is full, hold skip_ready low even if a pop occurs in the same cycle; no pass-through.
REQ-013 SHALL drive act_ready high only when the FIFO is non-empty and the output register is empty or out_ready is high.
REQ-014 SHALL, when the FIFO is empty, hold act_ready low; a skip element written in cycle N is usable no earlier than cycle N+1.
REQ-015 SHALL, on an act transfer, pop exactly one FIFO entry and load the output register with sat(act_data + FIFO head).
REQ-016 SHALL form the sum at DATA_WIDTH+1 bits sign-extended, then clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-017 SHALL have latency of exactly one cycle: out_valid rises on the cycle after the act transfer.
REQ-018 SHALL hold out_data, out_last and out_valid stable while out_valid is high and out_ready is low.
REQ-019 SHALL clear out_valid after an output transfer unless a new act transfer occurs in the same cycle, giving full throughput of one element per cycle.
REQ-020 SHALL accept a FIFO push and a pop in the same cycle, leaving occupancy unchanged.
REQ-021 SHALL keep an element index counter 0..TENSOR_LEN-1 that advances on each act transfer and wraps to 0 after TENSOR_LEN-1.
REQ-022 SHALL set out_last on the output element whose index is TENSOR_LEN-1.
REQ-023 SHALL neither drop nor duplicate elements under any valid/ready pattern; pairing is strictly in arrival order.

Reset
REQ-024 SHALL, when rst_n is low at a clock edge, clear FIFO pointers and occupancy, the element index, out_valid, out_data and out_last to 0.
REQ-025 SHALL drive skip_ready and act_ready low while rst_n is low.
REQ-026 SHALL discard all buffered and in-flight elements on reset mid-tensor; the next element after reset has index 0.

Configuration
REQ-027 SHALL, with macro RESADD_SAT_CNT_EN defined, provide output port sat_count (16 bits), reset to 0, incremented on each act transfer whose sum clamps, and held at 0xFFFF once reached.
REQ-028 SHALL, without RESADD_SAT_CNT_EN, omit the sat_count port and its logic; all other behaviour is identical.

Verification
REQ-029 SHALL cover: DATA_WIDTH=16, skip 0x0100 then act 0x0200 with out_ready=1 -> out_data 0x0300 one cycle after the act transfer.
REQ-030 SHALL cover: skip 0x7000 with act 0x2000 -> 0x7FFF; skip 0x9000 with act 0xC000 -> 0x8000; sat_count=2 when RESADD_SAT_CNT_EN is defined.
REQ-031 SHALL cover: 16 skip pushes with no act -> skip_ready low after the 16th; act_ready low while the FIFO is empty.
REQ-032 SHALL cover: TENSOR_LEN=4, 8 back-to-back pairs -> out_last high on outputs 4 and 8 only, one output per cycle.
REQ-033 SHALL cover: out_ready low for 5 cycles while out_valid is high -> out_data stable, act_ready low, no loss after release.
REQ-034 SHALL cover: rst_n low after 3 of 4 elements -> outputs cleared; the next tensor's out_last falls on its 4th element.
